ahb_button_input: RTL
=====================

// Module: ahb_button_input
// PURPOSE
//  AHB-Lite read-side peripheral: carries user input from the board to software, the opposite direction to the display sink.
//  Synchronises and debounces NUM_BUTTONS active-low push buttons (nMode, nTrip, ...).
//  Exposes debounced level, sticky read-to-clear press flags and per-button press counters on the bus.
//  Sits on the cycle-computer AHB bus, polled by firmware; zero wait states.
// PARAMETERS
//  NUM_BUTTONS      2     number of button inputs, 1..4
//  DEBOUNCE_CYCLES  1000  consecutive stable HCLK cycles needed before the debounced level changes; >=2
// PORTS
//  HCLK       in   1   bus/system clock, single clock domain
//  HRESETn    in   1   reset, synchronous, active-low
//  HADDR      in   32  address; only HADDR[3:2] decoded
//  HWDATA     in   32  ignored (block is read-only)
//  HWRITE     in   1   transfer direction
//  HREADY     in   1   bus ready
//  HSEL       in   1   slave select
//  HSIZE      in   3   ignored; full-word reads assumed
//  HTRANS     in   2   transfer type; valid when HTRANS[1]=1 (NONSEQ/SEQ)
//  HRDATA     out  32  read data, valid in the data phase
//  HREADYOUT  out  1   tied 1
//  nButton    in   NUM_BUTTONS  raw asynchronous buttons, 0 = pressed
// BEHAVIOUR
//  Reset (HRESETn low at a rising HCLK edge):
//   - All flags, levels, counters and debounce counters go to 0.
//   - Synchroniser flops go to 1 (released).
//   - Pending bus transfer is dropped; HRDATA is 0 from the next cycle.
//  Synchroniser: 2-flop per button; raw_sync = ~nButton after 2 edges.
//  Debounce, evaluated at each edge, per button:
//   - raw_sync == level: cnt <= 0.
//   - Otherwise, if cnt == DEBOUNCE_CYCLES-1: level <= raw_sync, cnt <= 0.
//   - Otherwise: cnt++.
//   - Latency: nButton low before edge k, held stable -> level=1 at edge k+1+DEBOUNCE_CYCLES.
//   - A bounce shorter than DEBOUNCE_CYCLES has no effect.
//  Press event: level 0->1. At the same edge the flag sets and the 8-bit counter increments (wraps 0xFF->0x00).
//   - Release (1->0) produces no event.
//  Bus address phase: accepted when HSEL & HREADY & HTRANS[1].
//   - Registers rd_pend = ~HWRITE and addr_q = HADDR[3:2].
//   - Otherwise rd_pend <= 0.
//   - Writes are accepted with OKAY and ignored.
//  Data phase: HRDATA is combinational from addr_q and the current register state while rd_pend = 1, else 0.
//  Register map (addr_q):
//   - 0 FLAGS: [NUM_BUTTONS-1:0] sticky press flags; read-to-clear.
//   - 1 LEVEL: [NUM_BUTTONS-1:0] debounced levels.
//   - 2 COUNT: [8i+7:8i] press counter for button i.
//   - 3: reads 0.
//   - Unused bits read 0.
//  Read-to-clear: the edge ending a FLAGS data phase clears every flag that was 1 in the returned data.
//   - A press event at that same edge wins: that flag stays 1. No event is ever lost.
//   - Back-to-back FLAGS reads: the second read returns only events that occurred after the first data phase.
//  Only a FLAGS read clears flags. LEVEL and COUNT reads have no side effects.
//  Simultaneous events on different buttons are independent; all set in the same cycle.
//  HREADYOUT = 1 always; never signals ERROR.
// STRUCTURE
//  Shared package button_pkg:
//   - Register offsets FLAGS_ADDR=0, LEVEL_ADDR=1, COUNT_ADDR=2.
//   - HTRANS_IDLE / HTRANS_NONSEQ constants.
//   - Counter width 8.
//  Sub-module button_debounce, one per button via generate:
//   - Contains the synchroniser, debounce counter ($clog2(DEBOUNCE_CYCLES) bits), level and press pulse output.
//  Top level holds the bus phase register, flags, counters and the read mux.
// TESTING (DEBOUNCE_CYCLES=4, NUM_BUTTONS=2)
//  1. Reset, buttons idle; read addresses 0,1,2,3 -> HRDATA 0 each; HREADYOUT 1 throughout.
//  2. nButton[0] low before edge k, held -> LEVEL=0x1 from edge k+5, FLAGS=0x1, COUNT=0x0001; release -> LEVEL=0 after 5 more edges, COUNT unchanged.
//  3. nButton[1] low for 3 cycles, then high (glitch) -> LEVEL, FLAGS, COUNT stay 0.
//  4. After one press on button 0, read FLAGS twice back-to-back -> 0x1 then 0x0; LEVEL reads do not clear.
//  5. Button 1 press event lands on the edge ending a FLAGS read that returns 0x1 -> FLAGS reads 0x2 next.
//  6. 256 presses on button 0 -> COUNT[7:0] wraps to 0x00; writes of 0xFFFFFFFF to addresses 0-2 change nothing.
//  7. Assert HRESETn mid-debounce (cnt=2) -> after release, no press event, all registers 0, no spurious flag.

Source files
------------

// File: rtl/button_pkg.sv
// Shared constants for the button input peripheral:
// register offsets, bus transfer encodings and counter width.
package button_pkg;

  localparam logic [1:0] FLAGS_ADDR = 2'd0;
  localparam logic [1:0] LEVEL_ADDR = 2'd1;
  localparam logic [1:0] COUNT_ADDR = 2'd2;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam int CNT_W = 8;

  // NONSEQ and SEQ both carry HTRANS[1]; IDLE and BUSY do not.
  function automatic logic trans_valid(input logic [1:0] t);
    return (t & HTRANS_NONSEQ) != HTRANS_IDLE;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button: two-flop synchroniser, stability counter,
// debounced level and a single-cycle press pulse.
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          raw;
  logic          hit;
  logic [CW-1:0] cnt;

  assign raw = ~s2;
  assign hit = (raw != level) && (cnt == CMAX);
  // Pulse on the edge that raises the level, so the
  // flag and counter update together with it.
  assign press = hit & raw;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= btn_n;
      s2 <= s1;
      if (raw == level) begin
        cnt <= '0;
      end else if (hit) begin
        level <= raw;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ahb_button_input.sv
// AHB-Lite read-only button peripheral: debounced levels,
// read-to-clear press flags and per-button press counters.
module ahb_button_input
  import button_pkg::*;
#(
  parameter int NUM_BUTTONS     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [31:0]            HADDR,
  input  logic [31:0]            HWDATA,
  input  logic                   HWRITE,
  input  logic                   HREADY,
  input  logic                   HSEL,
  input  logic [2:0]             HSIZE,
  input  logic [1:0]             HTRANS,
  output logic [31:0]            HRDATA,
  output logic                   HREADYOUT,
  input  logic [NUM_BUTTONS-1:0] nButton
);

  logic [NUM_BUTTONS-1:0] level;
  logic [NUM_BUTTONS-1:0] press;
  logic [NUM_BUTTONS-1:0] flags;
  logic [NUM_BUTTONS-1:0] clr;
  logic [CNT_W-1:0]       count [NUM_BUTTONS];

  logic        accept;
  logic        rd_pend;
  logic [1:0]  addr_q;
  logic [31:0] flags_w;
  logic [31:0] level_w;
  logic [31:0] count_w;
  logic        unused;

  assign unused = ^{HWDATA, HSIZE, HADDR[31:4], HADDR[1:0]};

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (HCLK),
      .rst_n(HRESETn),
      .btn_n(nButton[i]),
      .level(level[i]),
      .press(press[i])
    );
  end

  assign accept = HSEL & HREADY & trans_valid(HTRANS);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rd_pend <= 1'b0;
      addr_q  <= '0;
    end else begin
      rd_pend <= accept & ~HWRITE;
      if (accept) addr_q <= HADDR[3:2];
    end
  end

  // Clear only what was returned; a press at this edge re-sets.
  assign clr = (rd_pend && addr_q == FLAGS_ADDR) ? flags : '0;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      flags <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) count[i] <= '0;
    end else begin
      flags <= (flags & ~clr) | press;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (press[i]) count[i] <= count[i] + CNT_W'(1);
      end
    end
  end

  assign flags_w = {{(32-NUM_BUTTONS){1'b0}}, flags};
  assign level_w = {{(32-NUM_BUTTONS){1'b0}}, level};

  always_comb begin
    count_w = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      count_w[CNT_W*i +: CNT_W] = count[i];
    end
  end

  always_comb begin
    HRDATA = '0;
    if (rd_pend) begin
      unique case (1'b1)
        (addr_q == FLAGS_ADDR): HRDATA = flags_w;
        (addr_q == LEVEL_ADDR): HRDATA = level_w;
        (addr_q == COUNT_ADDR): HRDATA = count_w;
        default:                HRDATA = '0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;

endmodule
